uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

- Command parser FSM between the UART receiver/transmitter and the 256 x 8-bit `ram` block.
- Assembles incoming bytes into write and read commands and drives the RAM write and read-strobe ports.
- Returns read data, and optionally a write acknowledge, as bytes to the UART transmitter.
- Drops malformed or stalled commands using an inter-byte timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 100000: maximum clk cycles between bytes inside a command before it is abandoned. A value of 0 disables the timeout.

Ports:
- `clk` input 1: single clock; all logic is on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: one-cycle pulse; `rx_data` is valid in that cycle.
- `tx_data` output 8: byte to transmit.
- `tx_valid` output 1: transmit request.
- `tx_ready` input 1: the transmitter accepts `tx_data` in a cycle where `tx_valid && tx_ready`.
- `ram_write_en` output 1: RAM write enable, one-cycle pulse.
- `ram_read_strobe` output 1: RAM read strobe, one-cycle pulse.
- `ram_addr` output 8: RAM address.
- `ram_write_data` output 8: RAM write data.
- `ram_read_data` input 8: RAM read data, registered in the RAM, valid one cycle after the strobe.
- `busy` output 1: high in any state other than IDLE.
- `err` output 1: one-cycle pulse on a bad opcode or a timeout.

## Operation

Command formats:
- Write: `0x57` ('W'), addr, data.
- Read: `0x52` ('R'), addr. Response is one byte: `ram[addr]`.

States:
- IDLE: on `rx_valid`:
  - 'W' → GET_ADDR with a write flag set.
  - 'R' → GET_ADDR with the write flag clear.
  - Any other byte → `err` pulse, stay in IDLE.
- GET_ADDR: on `rx_valid`, latch `ram_addr`. Write → GET_DATA. Read → DO_READ.
- GET_DATA: on `rx_valid`, latch `ram_write_data` → DO_WRITE.
- DO_WRITE: `ram_write_en` = 1 for exactly one cycle → IDLE (or SEND_ACK, see Configuration).
- DO_READ: `ram_read_strobe` = 1 for exactly one cycle → READ_WAIT.
- READ_WAIT: register `ram_read_data` into `tx_data` → SEND.
- SEND: `tx_valid` = 1 and `tx_data` held stable until `tx_ready` → IDLE.

Rules and boundary conditions:
- `rx_valid` during DO_WRITE, DO_READ, READ_WAIT, SEND or SEND_ACK: the byte is dropped silently, with no `err`.
- Timeout counter:
  - Clears on every accepted byte and counts while in GET_ADDR or GET_DATA.
  - Reaching `TIMEOUT_CYCLES` → IDLE with an `err` pulse; no RAM access occurs.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`, and the counter saturates.
- `rx_valid` in the same cycle the timeout expires: the byte is accepted and the timeout is ignored.
- Address 0xFF is legal; there is no address wrap or auto-increment.
- `ram_addr` and `ram_write_data` hold their last latched values between commands.
- `ram_write_en` and `ram_read_strobe` are never high in the same cycle.
- Reset asserted mid-command:
  - Immediately returns the FSM to IDLE.
  - Drops `tx_valid`.
  - Suppresses any pending write; no write occurs after `rst_n` falls.

## Timing

- Reset values: `tx_data` = 0, `tx_valid` = 0, `ram_write_en` = 0, `ram_read_strobe` = 0, `ram_addr` = 0, `ram_write_data` = 0, `busy` = 0, `err` = 0; state IDLE; timeout counter 0.
- Write: last (data) byte accepted in cycle N → `ram_write_en` high in cycle N+1 → IDLE in N+2.
- Read: addr byte accepted in cycle N:
  - `ram_read_strobe` high in cycle N+1.
  - RAM output valid in cycle N+2.
  - `tx_valid` high from cycle N+3.
- Back-to-back commands: a new opcode is accepted in the first cycle the FSM is back in IDLE.
- `err` is registered and asserts the cycle after its cause.

## Configuration

- Macro: `UART_CMD_ACK_EN`.
- Defined:
  - DO_WRITE → SEND_ACK.
  - SEND_ACK presents `tx_data` = `0x4B` ('K') with `tx_valid` until `tx_ready` → IDLE.
  - `busy` stays high throughout SEND_ACK.
- Undefined: SEND_ACK does not exist, writes produce no transmit traffic, and `tx_valid` asserts only for read responses.

## Test plan

1. Reset then idle: all outputs 0, state IDLE, `busy` = 0 for 10 cycles with no stimulus.
2. Write then read:
   - Send 'W', 0x3C, 0xA5 → `ram_write_en` pulses once with `ram_addr` = 0x3C and `ram_write_data` = 0xA5.
   - Send 'R', 0x3C → `tx_data` = 0xA5 with `tx_valid` in cycle N+3.
   - With `UART_CMD_ACK_EN` defined, 'K' is transmitted after the write.
3. Transmit backpressure:
   - Read of 0xFF (preloaded 0x77) with `tx_ready` held low for 20 cycles → `tx_valid` and `tx_data` = 0x77 stay stable throughout.
   - One handshake then occurs, followed by a return to IDLE.
   - An `rx_valid` byte injected during SEND is dropped and causes no `err`.
4. Bad opcode: send 0x00, then 'R', 0x10 → one `err` pulse, then a normal read of address 0x10.
5. Timeout (`TIMEOUT_CYCLES` = 16):
   - Send 'W', 0x20, then wait 16 cycles → `err` pulse, state IDLE.
   - A following 0x99 byte is treated as a bad opcode; no write ever occurs.
6. Reset mid-command: send 'W', 0x01, 0x02, then assert `rst_n` = 0 during DO_WRITE → no `ram_write_en` pulse after the `rst_n` fall, and all outputs are at their reset values.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Byte-command parser between the UART and a 256 x 8 RAM: 'W' addr data writes, 'R' addr reads back one byte.
// Optional macro UART_CMD_ACK_EN adds a 'K' transmit acknowledge after every write.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       ram_write_en,
    output logic       ram_read_strobe,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_write_data,
    input  logic [7:0] ram_read_data,
    output logic       busy,
    output logic       err,
    output logic [2:0] state_dbg
);

    // Transmit handshake: a byte transfers in any cycle with tx_valid && tx_ready; while tx_valid
    // is high and tx_ready low, tx_data is held stable. rx_valid is a one-cycle pulse with no backpressure.

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GET_ADDR  = 3'd1;
    localparam logic [2:0] S_GET_DATA  = 3'd2;
    localparam logic [2:0] S_DO_WRITE  = 3'd3;
    localparam logic [2:0] S_DO_READ   = 3'd4;
    localparam logic [2:0] S_READ_WAIT = 3'd5;
    localparam logic [2:0] S_SEND      = 3'd6;
`ifdef UART_CMD_ACK_EN
    localparam logic [2:0] S_SEND_ACK  = 3'd7;
    localparam logic [7:0] ACK_BYTE    = 8'h4B;
`endif

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic             is_write;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_get;
    logic             timeout_hit;
    logic             bad_opcode;

    assign in_get      = (state == S_GET_ADDR) || (state == S_GET_DATA);
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_get && !rx_valid && (tmo_cnt == CNT_MAX);
    assign bad_opcode  = (state == S_IDLE) && rx_valid && (rx_data != OP_WRITE) && (rx_data != OP_READ);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (rx_valid && ((rx_data == OP_WRITE) || (rx_data == OP_READ))) begin
                    state_nx = S_GET_ADDR;
                end
            end
            S_GET_ADDR: begin
                if (rx_valid) begin
                    state_nx = is_write ? S_GET_DATA : S_DO_READ;
                end else if (timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (rx_valid) begin
                    state_nx = S_DO_WRITE;
                end else if (timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
`ifdef UART_CMD_ACK_EN
            S_DO_WRITE:  state_nx = S_SEND_ACK;
            S_SEND_ACK:  state_nx = tx_ready ? S_IDLE : S_SEND_ACK;
`else
            S_DO_WRITE:  state_nx = S_IDLE;
`endif
            S_DO_READ:   state_nx = S_READ_WAIT;
            S_READ_WAIT: state_nx = S_SEND;
            S_SEND:      state_nx = tx_ready ? S_IDLE : S_SEND;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            is_write       <= 1'b0;
            tmo_cnt        <= '0;
            ram_addr       <= 8'h00;
            ram_write_data <= 8'h00;
            tx_data        <= 8'h00;
            err            <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= bad_opcode || timeout_hit;

            if (!in_get || rx_valid) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != CNT_MAX) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if ((state == S_IDLE) && rx_valid) begin
                is_write <= (rx_data == OP_WRITE);
            end
            if ((state == S_GET_ADDR) && rx_valid) begin
                ram_addr <= rx_data;
            end
            if ((state == S_GET_DATA) && rx_valid) begin
                ram_write_data <= rx_data;
            end
            if (state == S_READ_WAIT) begin
                tx_data <= ram_read_data;
            end
`ifdef UART_CMD_ACK_EN
            if (state == S_DO_WRITE) begin
                tx_data <= ACK_BYTE;
            end
`endif
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills a pending write at once.
    assign ram_write_en    = (state == S_DO_WRITE);
    assign ram_read_strobe = (state == S_DO_READ);
`ifdef UART_CMD_ACK_EN
    assign tx_valid        = (state == S_SEND) || (state == S_SEND_ACK);
`else
    assign tx_valid        = (state == S_SEND);
`endif
    assign busy            = (state != S_IDLE);
    assign state_dbg       = state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: table of write/read commands plus hand-written corner sequences.
// Honours UART_CMD_ACK_EN when the design is built with it.
module tb_uart_cmd_parser;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GET_ADDR  = 3'd1;
    localparam logic [2:0] S_GET_DATA  = 3'd2;
    localparam logic [2:0] S_READ_WAIT = 3'd5;
    localparam logic [2:0] S_SEND      = 3'd6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ram_write_en;
    logic       ram_read_strobe;
    logic [7:0] ram_addr;
    logic [7:0] ram_write_data;
    logic [7:0] ram_read_data;
    logic       busy;
    logic       err;
    logic [2:0] state_dbg;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;
    vec_t vecs[9];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ram_write_en(ram_write_en), .ram_read_strobe(ram_read_strobe),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // RAM model: preloaded with addr ^ 0x3C, except 0xFF which holds 0x77.
    logic [7:0] mem [256];
    logic       loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
            mem[255]      <= 8'h77;
            ram_read_data <= 8'h00;
            loaded        <= 1'b1;
        end else begin
            if (ram_write_en)    mem[ram_addr] <= ram_write_data;
            if (ram_read_strobe) ram_read_data <= mem[ram_addr];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Every transmit handshake must match the next expected byte.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL tx_unexpected: got %0h required none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    fails++;
                    $display("FAIL tx_byte: got %0h required %0h", tx_data, e);
                end
            end
        end
    end

    function automatic logic [31:0] out_vec();
        return {tx_data, tx_valid, ram_write_en, ram_read_strobe, ram_addr,
                ram_write_data, busy, err, state_dbg};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // Returns at the negedge of the cycle after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 tx_ready = v;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 64) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
`ifdef UART_CMD_ACK_EN
        exp_q.push_back(8'h4B);
`endif
        send_byte(8'h57);
        check("wr_get_addr", state_dbg, S_GET_ADDR);
        send_byte(a);
        check("wr_get_data", state_dbg, S_GET_DATA);
        send_byte(d);
        check("wr_pulse", {ram_write_en, ram_read_strobe, ram_addr, ram_write_data}, {2'b10, a, d});
        tick();
        check("wr_pulse_end", ram_write_en, 1'b0);
`ifdef UART_CMD_ACK_EN
        check("wr_ack", {tx_valid, tx_data, busy}, {1'b1, 8'h4B, 1'b1});
        tick();
        check("wr_ack_idle", state_dbg, S_IDLE);
`else
        check("wr_idle", {busy, tx_valid}, 2'b00);
`endif
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d);
        exp_q.push_back(d);
        send_byte(8'h52);
        send_byte(a);
        check("rd_strobe", {ram_read_strobe, ram_write_en, ram_addr}, {2'b10, a});
        tick();
        check("rd_wait", {ram_read_strobe, state_dbg}, {1'b0, S_READ_WAIT});
        tick();
        check("rd_tx", {tx_valid, tx_data}, {1'b1, d});
        tick();
        check("rd_idle", busy, 1'b0);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{1'b1, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 8'h3C, 8'hA5};
        vecs[2] = '{1'b1, 8'h00, 8'h5A};
        vecs[3] = '{1'b1, 8'h80, 8'hC3};
        vecs[4] = '{1'b0, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 8'h80, 8'hC3};
        vecs[6] = '{1'b0, 8'h10, 8'h2C};
        vecs[7] = '{1'b1, 8'hFE, 8'h01};
        vecs[8] = '{1'b0, 8'hFE, 8'h01};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("reset_state", out_vec(), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", out_vec(), 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
            else               do_read(vecs[i].addr, vecs[i].data);
        end

        // Backpressure on a read of 0xFF, with a stray byte injected during SEND.
        set_ready(1'b0);
        exp_q.push_back(8'h77);
        send_byte(8'h52);
        send_byte(8'hFF);
        check("bp_strobe", {ram_read_strobe, ram_addr}, {1'b1, 8'hFF});
        tick();
        tick();
        for (int k = 0; k < 20; k++) begin
            check("bp_hold", {tx_valid, tx_data, err, state_dbg}, {1'b1, 8'h77, 1'b0, S_SEND});
            rx_data  = 8'h57;
            rx_valid = (k == 5);
            tick();
        end
        rx_valid = 1'b0;
        set_ready(1'b1);
        tick();
        tick();
        check("bp_idle", {state_dbg, err}, {S_IDLE, 1'b0});
        repeat (3) tick();
        check("bp_drop", {busy, err}, 2'b00);
        check("bp_sent", exp_q.size(), 0);

        // Bad opcode then a normal read.
        send_byte(8'h00);
        check("bad_op_err", {err, busy}, 2'b10);
        tick();
        check("bad_op_err_end", err, 1'b0);
        do_read(8'h10, 8'h2C);

        // Timeout in GET_DATA.
        send_byte(8'h57);
        send_byte(8'h20);
        check("tmo_get_data", state_dbg, S_GET_DATA);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("tmo_wait", {busy, err}, 2'b10);
        end
        tick();
        check("tmo_err", {err, state_dbg, ram_write_en}, {1'b1, S_IDLE, 1'b0});
        send_byte(8'h99);
        check("tmo_then_bad", {err, busy}, 2'b10);
        check("tmo_no_write", mem[8'h20], 8'h1C);

        // Byte arriving in the expiry cycle is accepted.
        send_byte(8'h57);
        send_byte(8'h21);
        repeat (15) tick();
        send_byte(8'hE7);
        check("tmo_edge_wr", {ram_write_en, err, ram_addr, ram_write_data}, {2'b10, 8'h21, 8'hE7});
        wait_idle();
        check("tmo_edge_noerr", err, 1'b0);
        do_read(8'h21, 8'hE7);

        // Reset during DO_WRITE suppresses the write.
        send_byte(8'h57);
        send_byte(8'h01);
        send_byte(8'h02);
        check("rst_mid_pre", ram_write_en, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("rst_mid_out", out_vec(), 32'h0);
        repeat (3) tick();
        check("rst_mid_no_write", mem[8'h01], 8'h3D);
        rst_n = 1'b1;
        tick();
        check("rst_release", out_vec(), 32'h0);
        do_read(8'h01, 8'h3D);

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
